// File: rtl/apb_slave_regfile_pkg.sv
// Shared types and elaboration helpers for the parametrised APB register-file slave.
package apb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    // A single-entry file still needs a one-bit index bus.
    function automatic int idx_width(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x DATA_W register storage with byte-lane writes; entry 0 is a constant ID.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 16,
    parameter int                IDX_W    = 4,
    parameter logic [DATA_W-1:0] ID_VALUE = '0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_we,
    input  logic [IDX_W-1:0]    i_idx,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic [DATA_W-1:0]   o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage update; entry 0 is only ever loaded by reset, so the ID cannot be overwritten.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= ID_VALUE;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                for (int b = 0; b < DATA_W / 8; b++) begin
                    if (i_we && (i_idx == IDX_W'(i)) && i_wstrb[b]) begin
                        r_mem[i][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB4-style slave: setup/access FSM, programmable wait states and error decode
// in front of one apb_regfile instance.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h0000_00A5
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic                PWRITE,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int LANE_W = lane_bits(DATA_W);
    localparam int IDX_W  = idx_width(DEPTH);
    localparam int FULL_W = ADDR_W - LANE_W;

    apb_state_e        r_state;
    apb_state_e        w_next_state;
    logic [3:0]        r_cnt;
    logic [3:0]        w_next_cnt;
    logic [FULL_W-1:0] w_full_idx;
    logic [IDX_W-1:0]  w_idx;
    logic              w_in_range;
    logic              w_sel_en;
    logic              w_ready;
    logic              w_err;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata;

    // The whole word index, including bits above the storage index, decides range.
    assign w_full_idx = PADDR[ADDR_W-1:LANE_W];
    assign w_idx      = w_full_idx[IDX_W-1:0];
    assign w_in_range = ({1'b0, w_full_idx} < (FULL_W + 1)'(DEPTH));
    assign w_sel_en   = PSEL && PENABLE;

    generate
        if (LANE_W > 0) begin : g_lane_unused
            logic w_unused_lane;
            assign w_unused_lane = ^PADDR[LANE_W-1:0];
        end
    endgenerate

    // State and wait-counter registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state logic: a stray PENABLE in IDLE is ignored, a dropped select aborts ACCESS.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_next_state = ACCESS;
                    w_next_cnt   = 4'(WAIT_CYCLES);
                end else begin
                    w_next_state = IDLE;
                end
            end
            ACCESS: begin
                if (!w_sel_en) begin
                    w_next_state = IDLE;
                    w_next_cnt   = 4'd0;
                end else if (r_cnt == 4'd0) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // Completion and error decode; address/control are sampled at the completing edge.
    always_comb begin
        w_ready = 1'b0;
        w_err   = 1'b0;
        w_we    = 1'b0;
        PRDATA  = '0;
        if ((r_state == ACCESS) && w_sel_en && (r_cnt == 4'd0)) begin
            w_ready = 1'b1;
        end else begin
            w_ready = 1'b0;
        end
        if (!w_in_range || (PWRITE && (w_idx == '0))) begin
            w_err = 1'b1;
        end else begin
            w_err = 1'b0;
        end
        if (w_ready && PWRITE && !w_err) begin
            w_we = 1'b1;
        end else begin
            w_we = 1'b0;
        end
        if (w_ready && !PWRITE && w_in_range) begin
            PRDATA = w_rdata;
        end else begin
            PRDATA = '0;
        end
    end

    assign PREADY  = w_ready;
    assign PSLVERR = (w_ready && w_err) ? RESP_SLVERR : RESP_OKAY;

    apb_regfile #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W),
        .ID_VALUE (DATA_W'(ID_VALUE))
    ) u_regfile (
        .i_clk   (PCLK),
        .i_rst   (PRESET),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wstrb (PSTRB),
        .i_wdata (PWDATA),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: four builds (0/3/2 wait states at 32 bits, one 8-bit)
// sharing one bus, driven from a vector table plus abort and mid-access reset sequences.
module tb_apb_slave_regfile;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [3:0]  psel;
    logic        PENABLE;
    logic [7:0]  PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;

    logic [31:0] rdata0, rdata1, rdata2;
    logic [7:0]  rdata3;
    logic [3:0]  ready, slverr;

    int          cur;
    logic [31:0] t_rdata;
    logic        t_ready, t_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 PCLK = ~PCLK;

    apb_slave_regfile #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(0)) u_w0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(rdata0),
        .PREADY(ready[0]), .PSLVERR(slverr[0]));

    apb_slave_regfile #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(3)) u_w3 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(rdata1),
        .PREADY(ready[1]), .PSLVERR(slverr[1]));

    apb_slave_regfile #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(2)) u_w2 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(rdata2),
        .PREADY(ready[2]), .PSLVERR(slverr[2]));

    apb_slave_regfile #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(0)) u_b8 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[3]), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA[7:0]), .PSTRB(PSTRB[0:0]), .PRDATA(rdata3),
        .PREADY(ready[3]), .PSLVERR(slverr[3]));

    always_comb begin
        t_ready = ready[cur];
        t_err   = slverr[cur];
        case (cur)
            0:       t_rdata = rdata0;
            1:       t_rdata = rdata1;
            2:       t_rdata = rdata2;
            default: t_rdata = {24'h0, rdata3};
        endcase
    end

    typedef struct {
        int          d;
        logic [7:0]  a;
        logic        w;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] erd;
        logic        eerr;
        int          ecyc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One complete transfer; cyc counts setup plus access cycles up to PREADY (capped at 40).
    task automatic xfer(input int d, input logic [7:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic err,
                        output int cyc, output logic leak);
        cur  = d;
        leak = 1'b0;
        @(negedge PCLK);
        psel = 4'b0000;
        psel[d] = 1'b1;
        PENABLE = 1'b0;
        PADDR = a; PWRITE = w; PWDATA = wd; PSTRB = st;
        @(negedge PCLK);
        PENABLE = 1'b1;
        cyc = 2;
        #1;
        while (!t_ready && cyc < 40) begin
            if (t_rdata != 32'h0 || t_err) leak = 1'b1;
            @(negedge PCLK);
            #1;
            cyc++;
        end
        rd  = t_rdata;
        err = t_err;
        @(negedge PCLK);
        psel = 4'b0000;
        PENABLE = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err, leak;
        int          cyc;

        // d, addr, write, wdata, strb, expected rdata, expected slverr, expected cycles
        vecs.push_back('{0, 8'h04, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 2});
        vecs.push_back('{0, 8'h04, 1'b0, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2});
        vecs.push_back('{0, 8'h08, 1'b1, 32'h11223344, 4'hF, 32'h0,        1'b0, 2});
        vecs.push_back('{0, 8'h08, 1'b1, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 2});
        vecs.push_back('{0, 8'h08, 1'b0, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 2});
        vecs.push_back('{0, 8'h00, 1'b1, 32'h12345678, 4'hF, 32'h0,        1'b1, 2});
        vecs.push_back('{0, 8'h00, 1'b0, 32'h0,        4'h0, 32'h000000A5, 1'b0, 2});
        vecs.push_back('{0, 8'h40, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1, 2});
        vecs.push_back('{0, 8'h40, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 2});
        vecs.push_back('{0, 8'h48, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1, 2});
        vecs.push_back('{0, 8'h08, 1'b0, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 2});
        vecs.push_back('{0, 8'h80, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 2});
        vecs.push_back('{0, 8'h3C, 1'b1, 32'hFFFF0000, 4'h0, 32'h0,        1'b0, 2});
        vecs.push_back('{0, 8'h3C, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 2});
        vecs.push_back('{0, 8'h3E, 1'b1, 32'h0000BEEF, 4'h3, 32'h0,        1'b0, 2});
        vecs.push_back('{0, 8'h3C, 1'b0, 32'h0,        4'h0, 32'h0000BEEF, 1'b0, 2});
        vecs.push_back('{0, 8'h07, 1'b1, 32'h01020304, 4'hF, 32'h0,        1'b0, 2});
        vecs.push_back('{0, 8'h04, 1'b0, 32'h0,        4'h0, 32'h01020304, 1'b0, 2});
        vecs.push_back('{1, 8'h04, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 5});
        vecs.push_back('{1, 8'h04, 1'b1, 32'h5A5A5A5A, 4'hF, 32'h0,        1'b0, 5});
        vecs.push_back('{1, 8'h04, 1'b0, 32'h0,        4'h0, 32'h5A5A5A5A, 1'b0, 5});
        vecs.push_back('{3, 8'h01, 1'b1, 32'h00000005, 4'h1, 32'h0,        1'b0, 2});
        vecs.push_back('{3, 8'h01, 1'b0, 32'h0,        4'h0, 32'h00000005, 1'b0, 2});
        vecs.push_back('{3, 8'h00, 1'b1, 32'h00000077, 4'h1, 32'h0,        1'b1, 2});
        vecs.push_back('{3, 8'h00, 1'b0, 32'h0,        4'h0, 32'h000000A5, 1'b0, 2});
        vecs.push_back('{3, 8'h10, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 2});

        cur = 0;
        PRESET = 1'b1;
        psel = 4'b0000; PENABLE = 1'b0; PADDR = 8'h00; PWRITE = 1'b0;
        PWDATA = 32'h0; PSTRB = 4'h0;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        check("reset_pready", {28'h0, ready}, 32'h0);
        check("reset_pslverr", {28'h0, slverr}, 32'h0);
        check("reset_prdata", rdata0 | rdata1 | rdata2 | {24'h0, rdata3}, 32'h0);

        // Stray PENABLE with PSEL in IDLE must not start a transfer.
        psel = 4'b0001; PENABLE = 1'b1;
        repeat (3) @(negedge PCLK);
        #1;
        check("stray_enable_pready", {31'h0, ready[0]}, 32'h0);
        psel = 4'b0000; PENABLE = 1'b0;

        foreach (vecs[i]) begin
            xfer(vecs[i].d, vecs[i].a, vecs[i].w, vecs[i].wd, vecs[i].st, rd, err, cyc, leak);
            check($sformatf("v%0d_prdata", i), rd, vecs[i].erd);
            check($sformatf("v%0d_pslverr", i), {31'h0, err}, {31'h0, vecs[i].eerr});
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].ecyc);
            check($sformatf("v%0d_early_output", i), {31'h0, leak}, 32'h0);
        end

        // Abort: two-wait build, enable dropped after one access cycle of a write to reg3.
        cur = 2;
        @(negedge PCLK);
        psel = 4'b0100; PENABLE = 1'b0; PADDR = 8'h0C; PWRITE = 1'b1;
        PWDATA = 32'h12345678; PSTRB = 4'hF;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        check("abort_pready_low", {31'h0, t_ready}, 32'h0);
        @(negedge PCLK);
        psel = 4'b0000; PENABLE = 1'b0;
        repeat (2) @(negedge PCLK);
        xfer(2, 8'h0C, 1'b0, 32'h0, 4'h0, rd, err, cyc, leak);
        check("abort_reg3_unchanged", rd, 32'h0);
        check("abort_read_pslverr", {31'h0, err}, 32'h0);
        check("abort_back_to_idle_cycles", cyc, 4);

        // Reset asserted in the completing access cycle of a zero-wait write.
        cur = 0;
        @(negedge PCLK);
        psel = 4'b0001; PENABLE = 1'b0; PADDR = 8'h08; PWRITE = 1'b1;
        PWDATA = 32'h99999999; PSTRB = 4'hF;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        check("midrst_pready_before", {31'h0, t_ready}, 32'h1);
        PRESET = 1'b1;
        #1;
        check("midrst_pready_drop", {31'h0, t_ready}, 32'h0);
        @(negedge PCLK);
        psel = 4'b0000; PENABLE = 1'b0; PRESET = 1'b0;

        xfer(0, 8'h08, 1'b0, 32'h0, 4'h0, rd, err, cyc, leak);
        check("midrst_reg2_cleared", rd, 32'h0);
        xfer(0, 8'h04, 1'b0, 32'h0, 4'h0, rd, err, cyc, leak);
        check("midrst_reg1_cleared", rd, 32'h0);
        xfer(0, 8'h00, 1'b0, 32'h0, 4'h0, rd, err, cyc, leak);
        check("midrst_id_restored", rd, 32'h000000A5);
        xfer(1, 8'h04, 1'b0, 32'h0, 4'h0, rd, err, cyc, leak);
        check("midrst_w3_reg1_cleared", rd, 32'h0);
        xfer(3, 8'h01, 1'b0, 32'h0, 4'h0, rd, err, cyc, leak);
        check("midrst_b8_reg1_cleared", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- Parametrised APB (APB4-style) slave fronting a register file.
- Successor to the fixed 8-bit, zero-wait APB slave.
- Adds:
  - configurable address and data width, and register depth;
  - programmable wait states;
  - byte write strobes;
  - a read-only ID register;
  - PSLVERR on illegal accesses.
- Sits on the peripheral bus behind the APB bridge; one instance per peripheral register block.

Parameters:
- ADDR_W, 8: PADDR width in bits.
- DATA_W, 32: PWDATA/PRDATA width; must be 8, 16 or 32.
- DEPTH, 16: number of DATA_W-wide registers; power of two, ≤ 2^(ADDR_W-log2(DATA_W/8)).
- WAIT_CYCLES, 0: extra access-phase cycles before PREADY asserts (0..15).
- ID_VALUE, 'hA5: reset and permanent content of register 0 (read-only), zero-extended to DATA_W.

Ports:
- PCLK, in, 1: bus clock; all state updates on the rising edge.
- PRESET, in, 1: asynchronous, active-high reset.
- PSEL, in, 1: slave select.
- PENABLE, in, 1: access-phase indicator.
- PADDR, in, ADDR_W: byte address.
- PWRITE, in, 1: 1 = write, 0 = read.
- PWDATA, in, DATA_W: write data.
- PSTRB, in, DATA_W/8: byte-lane write enables.
- PRDATA, out, DATA_W: read data, valid only while PREADY=1 on a read.
- PREADY, out, 1: transfer completes on this cycle's rising edge.
- PSLVERR, out, 1: error response, valid only while PREADY=1.

Behaviour:
- Reset (PRESET=1, asynchronous):
  - state=IDLE, wait counter=0, PREADY=0, PSLVERR=0, PRDATA=0;
  - reg[0]=ID_VALUE, reg[1..DEPTH-1]=0;
  - everything holds while PRESET=1.
- Index: idx = PADDR[ADDR_W-1:log2(DATA_W/8)]; the low byte-offset bits are ignored.
- In-range test: idx < DEPTH. Any upper PADDR bit beyond the index width that is set makes the access out of range.
- FSM states: IDLE, ACCESS.
- IDLE:
  - stays while PSEL=0 or PENABLE=1 (stray enable is ignored);
  - on a rising edge with PSEL=1 and PENABLE=0 (setup phase): load counter=WAIT_CYCLES, go to ACCESS.
- ACCESS:
  - PREADY = (counter==0) & PSEL & PENABLE. This is combinational from registered state; no combinational path from PWDATA.
  - While counter>0 and PSEL&PENABLE: decrement each edge, PREADY=0.
  - On the edge with PSEL & PENABLE & PREADY: the transfer completes; the write commits on that same edge; go to IDLE.
  - Each new transfer requires a fresh setup phase.
  - If PSEL or PENABLE drops while in ACCESS before completion: abort, go to IDLE, no register change, no error.
- Latency: a transfer occupies 2+WAIT_CYCLES cycles (setup + access).
- Write commit: for each lane b with PSTRB[b]=1, reg[idx][8b+7:8b] <= PWDATA lane b. Lanes with PSTRB[b]=0 are unchanged. PSTRB=0 is a legal no-op with OKAY response.
- Read: PRDATA = reg[idx] while PREADY=1 & PWRITE=0 & in range; otherwise PRDATA=0.
- PSLVERR=1 with PREADY on:
  - out-of-range read or write;
  - write to idx 0 (ID register).
  On error: no register modified and PRDATA=0.
- Signals sampled during ACCESS: PADDR, PWRITE, PWDATA and PSTRB are taken at the completing edge. The bus must hold them stable from setup; the slave does not check this.
- Back-to-back transfers: setup may immediately follow completion (IDLE one cycle = the new setup).
- Mid-transfer reset: the transfer is discarded and no partial write occurs.

Decomposition:
- Package apb_pkg:
  - state enum {IDLE, ACCESS};
  - resp constants OKAY=0, SLVERR=1;
  - function clog2-based index-width helper.
- Sub-module apb_regfile:
  - DEPTH x DATA_W storage with per-byte write enable and async reset to ID/zero;
  - combinational read port;
  - instantiated once by apb_slave_regfile, which owns the FSM, wait counter and error decode.

Test Plan:
1. WAIT_CYCLES=0, DATA_W=32: write PADDR=0x04, PWDATA=0xDEADBEEF, PSTRB=4'hF, then read 0x04.
   -> PREADY high in the first access cycle; PRDATA=0xDEADBEEF; PSLVERR=0; 2 cycles per transfer.
2. WAIT_CYCLES=3: read of reg1.
   -> PREADY low for 3 access cycles, high on the 4th; total 5 cycles; PRDATA valid only with PREADY.
3. Byte strobes: reg2=0x11223344; write 0xAABBCCDD with PSTRB=4'b0101.
   -> readback 0x11BB33DD.
4. Errors:
   - write PADDR=0x00 -> PSLVERR=1, readback 0xA5;
   - write PADDR=0x40 (idx 16 ≥ DEPTH) -> PSLVERR=1, no register change;
   - read 0x40 -> PRDATA=0, PSLVERR=1.
5. Abort and reset:
   - WAIT_CYCLES=2; PENABLE dropped after 1 access cycle on a write of 0x12345678 to reg3 -> reg3 stays 0, FSM returns to IDLE;
   - PRESET pulsed mid-ACCESS -> PREADY=0 immediately and all registers reinitialised.
6. DATA_W=8, ADDR_W=8 build: write 0x05 to PADDR=0x01, read back.
   -> PRDATA=0x05 (matches legacy 8-bit slave behaviour).
